// File: rtl/unidade_controle_jogo.sv
// Control unit for the memory game: a Moore FSM that sequences the datapath
// counters, play register, ROM compare and play timer, and reports the game outcome.
module unidade_controle_jogo #(
   parameter logic TIMEOUT_HAB = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       jogada_feita,
   input  logic       chavesIgualMemoria,
   input  logic       enderecoIgualSequencia,
   input  logic       fimS,
   input  logic       fimTMR,
   output logic       zeraR,
   output logic       zeraE,
   output logic       zeraS,
   output logic       zeraTMR,
   output logic       registraR,
   output logic       contaE,
   output logic       contaS,
   output logic       contaTMR,
   output logic       pronto,
   output logic       ganhou,
   output logic       perdeu,
   output logic       db_timeout,
   output logic [3:0] db_estado
);

   typedef enum logic [3:0] {
      INICIAL           = 4'h0,
      PREPARACAO        = 4'h1,
      INICIA_RODADA     = 4'h2,
      ESPERA_JOGADA     = 4'h3,
      REGISTRA          = 4'h4,
      COMPARA           = 4'h5,
      PROXIMO_ENDERECO  = 4'h6,
      PROXIMA_SEQUENCIA = 4'h7,
      FIM_ACERTOU       = 4'hA,
      FIM_TIMEOUT       = 4'hD,
      FIM_ERROU         = 4'hE
   } estado_t;

   estado_t estado_q;
   estado_t estado_d;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q <= INICIAL;
      end else begin
         estado_q <= estado_d;
      end
   end

   // A play in the same cycle as timer expiry takes priority over the timeout.
   always_comb begin
      estado_d = INICIAL;
      case (estado_q)
         INICIAL:           estado_d = iniciar ? PREPARACAO : INICIAL;
         PREPARACAO:        estado_d = INICIA_RODADA;
         INICIA_RODADA:     estado_d = ESPERA_JOGADA;
         ESPERA_JOGADA: begin
            if (jogada_feita)
               estado_d = REGISTRA;
            else if (fimTMR && TIMEOUT_HAB)
               estado_d = FIM_TIMEOUT;
            else
               estado_d = ESPERA_JOGADA;
         end
         REGISTRA:          estado_d = COMPARA;
         COMPARA: begin
            if (!chavesIgualMemoria)
               estado_d = FIM_ERROU;
            else if (!enderecoIgualSequencia)
               estado_d = PROXIMO_ENDERECO;
            else if (fimS)
               estado_d = FIM_ACERTOU;
            else
               estado_d = PROXIMA_SEQUENCIA;
         end
         PROXIMO_ENDERECO:  estado_d = ESPERA_JOGADA;
         PROXIMA_SEQUENCIA: estado_d = INICIA_RODADA;
         FIM_ACERTOU:       estado_d = iniciar ? PREPARACAO : FIM_ACERTOU;
         FIM_ERROU:         estado_d = iniciar ? PREPARACAO : FIM_ERROU;
         FIM_TIMEOUT:       estado_d = iniciar ? PREPARACAO : FIM_TIMEOUT;
         default:           estado_d = INICIAL;
      endcase
   end

   always_comb begin
      zeraR      = 1'b0;
      zeraE      = 1'b0;
      zeraS      = 1'b0;
      zeraTMR    = 1'b0;
      registraR  = 1'b0;
      contaE     = 1'b0;
      contaS     = 1'b0;
      contaTMR   = 1'b0;
      pronto     = 1'b0;
      ganhou     = 1'b0;
      perdeu     = 1'b0;
      db_timeout = 1'b0;
      case (estado_q)
         PREPARACAO: begin
            zeraE   = 1'b1;
            zeraS   = 1'b1;
            zeraR   = 1'b1;
            zeraTMR = 1'b1;
         end
         INICIA_RODADA: begin
            zeraE   = 1'b1;
            zeraTMR = 1'b1;
         end
         ESPERA_JOGADA:     contaTMR = 1'b1;
         REGISTRA: begin
            registraR = 1'b1;
            zeraTMR   = 1'b1;
         end
         PROXIMO_ENDERECO:  contaE = 1'b1;
         PROXIMA_SEQUENCIA: contaS = 1'b1;
         FIM_ACERTOU: begin
            pronto = 1'b1;
            ganhou = 1'b1;
         end
         FIM_ERROU: begin
            pronto = 1'b1;
            perdeu = 1'b1;
         end
         FIM_TIMEOUT: begin
            pronto     = 1'b1;
            perdeu     = 1'b1;
            db_timeout = 1'b1;
         end
         default: ;
      endcase
   end

   assign db_estado = estado_q;

endmodule
